led_frame_scheduler: RTL and testbench

- APB3 slave that owns the LED-strip frame buffer, one 24-bit GRB word per LED.
- Sequences whole-frame transmission into a downstream single-wire bit encoder over a valid/ready bit stream, then enforces the strip latch (reset) gap.
- Supports one-shot and periodic auto-refresh, a busy/done status register and a level interrupt.

---
 rtl/led_frame_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_led_frame_scheduler.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module : led_frame_scheduler
// Desc   : APB3 LED frame buffer that streams GRB frames to a bit encoder.
// Rev    : 1.0 - initial release
// ============================================================================
module led_frame_scheduler #(
    parameter int NUM_LEDS     = 8,
    parameter int LATCH_CYCLES = 5000,
    parameter int REFRESH_W    = 24
) (
    input  logic        PCLK,
    input  logic        PRESERN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        bit_valid,
    output logic        bit_data,
    input  logic        bit_ready,
    output logic        strip_latch,
    output logic        irq
);

    localparam logic [3:0] c_NUM_LEDS    = 4'(NUM_LEDS);
    localparam logic [2:0] c_LAST_LED    = 3'(NUM_LEDS - 1);
    localparam logic [3:0] c_IDX_CTRL    = 4'd8;
    localparam logic [3:0] c_IDX_STATUS  = 4'd9;
    localparam logic [3:0] c_IDX_REFRESH = 4'd10;
    localparam int         c_LCW         = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam logic [c_LCW-1:0]     c_LAT_LAST = c_LCW'(LATCH_CYCLES - 1);
    localparam logic [c_LCW-1:0]     c_LAT_ONE  = c_LCW'(1);
    localparam logic [REFRESH_W-1:0] c_RF_ONE   = REFRESH_W'(1);
    localparam logic [REFRESH_W-1:0] c_RF_TWO   = REFRESH_W'(2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SEND  = 2'd2,
        S_LATCH = 2'd3
    } state_t;

    state_t               r_state;
    logic [23:0]          r_color  [0:7];
    logic [23:0]          r_shadow [0:7];
    logic                 r_auto;
    logic                 r_irq_en;
    logic                 r_done;
    logic                 r_pending;
    logic [REFRESH_W-1:0] r_refresh;
    logic [REFRESH_W-1:0] r_refresh_cnt;
    logic [2:0]           r_led_idx;
    logic [4:0]           r_bit_idx;
    logic [c_LCW-1:0]     r_latch_cnt;

    logic [3:0]  w_idx;
    logic        w_wr;
    logic        w_rd_setup;
    logic        w_color_sel;
    logic        w_start;
    logic        w_done_clr;
    logic        w_launch;
    logic        w_last_bit;
    logic        w_latch_end;
    logic [2:0]  w_next_led;
    logic [4:0]  w_next_bit;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;
    assign irq     = r_done & r_irq_en;

    assign w_idx       = PADDR[5:2];
    assign w_wr        = PSEL & PENABLE & PWRITE;
    assign w_rd_setup  = PSEL & ~PENABLE & ~PWRITE;
    assign w_color_sel = (w_idx < c_NUM_LEDS);
    assign w_start     = w_wr & (w_idx == c_IDX_CTRL) & PWDATA[0];
    assign w_done_clr  = w_wr & (w_idx == c_IDX_STATUS) & PWDATA[1];
    assign w_launch    = r_pending | (r_auto & (r_refresh_cnt == '0));
    assign w_last_bit  = (r_led_idx == c_LAST_LED) && (r_bit_idx == 5'd0);
    assign w_latch_end = (r_state == S_LATCH) && (r_latch_cnt == c_LAT_LAST);
    assign w_next_bit  = (r_bit_idx == 5'd0) ? 5'd23 : (r_bit_idx - 5'd1);
    assign w_next_led  = (r_bit_idx == 5'd0) ? (r_led_idx + 3'd1) : r_led_idx;
    assign w_unused    = &{1'b0, PADDR, PWDATA};

    always_comb begin
        w_rdata = '0;
        if (w_color_sel) begin
            w_rdata = {8'h00, r_color[w_idx[2:0]]};
        end else begin
            case (w_idx)
                c_IDX_CTRL:    w_rdata = {29'd0, r_irq_en, r_auto, 1'b0};
                c_IDX_STATUS:  w_rdata = {29'd0, r_pending, r_done, (r_state != S_IDLE)};
                c_IDX_REFRESH: w_rdata[REFRESH_W-1:0] = r_refresh;
                default:       w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            r_state       <= S_IDLE;
            r_auto        <= 1'b0;
            r_irq_en      <= 1'b0;
            r_done        <= 1'b0;
            r_pending     <= 1'b0;
            r_refresh     <= '0;
            r_refresh_cnt <= '0;
            r_led_idx     <= '0;
            r_bit_idx     <= '0;
            r_latch_cnt   <= '0;
            PRDATA        <= '0;
            bit_valid     <= 1'b0;
            bit_data      <= 1'b0;
            strip_latch   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_color[i]  <= '0;
                r_shadow[i] <= '0;
            end
        end else begin
            if (w_rd_setup) begin
                PRDATA <= w_rdata;
            end

            if (w_wr && w_color_sel) begin
                r_color[w_idx[2:0]] <= PWDATA[23:0];
            end
            if (w_wr && (w_idx == c_IDX_CTRL)) begin
                r_auto   <= PWDATA[1];
                r_irq_en <= PWDATA[2];
            end
            if (w_wr && (w_idx == c_IDX_REFRESH)) begin
                r_refresh <= PWDATA[REFRESH_W-1:0];
            end

            // A START arriving while IDLE is already launching merges into that frame
            if ((r_state == S_IDLE) && w_launch) begin
                r_pending <= 1'b0;
            end else if (w_start) begin
                r_pending <= 1'b1;
            end

            if (w_latch_end) begin
                r_done <= 1'b1;
            end else if (w_done_clr) begin
                r_done <= 1'b0;
            end

            // Reload is short by the IDLE-decision and LOAD cycles so LOAD recurs every REFRESH cycles
            if (r_state == S_LOAD) begin
                r_refresh_cnt <= (r_refresh > c_RF_TWO) ? (r_refresh - c_RF_TWO) : '0;
            end else if (r_auto && (r_refresh_cnt != '0)) begin
                r_refresh_cnt <= r_refresh_cnt - c_RF_ONE;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_shadow  <= r_color;
                    r_led_idx <= 3'd0;
                    r_bit_idx <= 5'd23;
                    bit_valid <= 1'b1;
                    bit_data  <= r_color[0][23];
                    r_state   <= S_SEND;
                end
                S_SEND: begin
                    if (bit_ready) begin
                        if (w_last_bit) begin
                            bit_valid   <= 1'b0;
                            bit_data    <= 1'b0;
                            strip_latch <= 1'b1;
                            r_latch_cnt <= '0;
                            r_state     <= S_LATCH;
                        end else begin
                            r_led_idx <= w_next_led;
                            r_bit_idx <= w_next_bit;
                            bit_data  <= r_shadow[w_next_led][w_next_bit];
                        end
                    end
                end
                S_LATCH: begin
                    if (w_latch_end) begin
                        strip_latch <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_latch_cnt <= r_latch_cnt + c_LAT_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_led_frame_scheduler
// Desc   : Directed self-checking bench for led_frame_scheduler.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_led_frame_scheduler;

    localparam int c_LAT = 5000;
    localparam logic [191:0] c_FRAME_RED   = {24'hFF0000, 168'h0};
    localparam logic [191:0] c_FRAME_GREEN = {24'h00FF00, 168'h0};

    logic        PCLK    = 1'b0;
    logic        PRESERN = 1'b0;
    logic        PSEL    = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE  = 1'b0;
    logic [31:0] PADDR   = '0;
    logic [31:0] PWDATA  = '0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        bit_valid;
    logic        bit_data;
    logic        bit_ready = 1'b1;
    logic        strip_latch;
    logic        irq;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic q[$];
    int   hold_viol  = 0;
    logic prev_valid = 1'b0;
    logic prev_ready = 1'b1;
    logic prev_data  = 1'b0;

    led_frame_scheduler #(
        .NUM_LEDS    (8),
        .LATCH_CYCLES(c_LAT),
        .REFRESH_W   (24)
    ) dut (
        .PCLK       (PCLK),
        .PRESERN    (PRESERN),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR),
        .bit_valid  (bit_valid),
        .bit_data   (bit_data),
        .bit_ready  (bit_ready),
        .strip_latch(strip_latch),
        .irq        (irq)
    );

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cyc <= cyc + 1;

    // Record accepted bits and flag any change of a stalled bit
    always @(negedge PCLK) begin
        if (bit_valid === 1'b1 && bit_ready === 1'b1) q.push_back(bit_data);
        if (prev_valid && !prev_ready && (bit_valid !== 1'b1 || bit_data !== prev_data))
            hold_viol <= hold_viol + 1;
        prev_valid <= (bit_valid === 1'b1);
        prev_ready <= bit_ready;
        prev_data  <= bit_data;
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic apb_write(input logic [3:0] idx, input logic [31:0] d);
        tick();
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0;
        PADDR = {26'd0, idx, 2'b00}; PWDATA = d;
        tick();
        PENABLE = 1'b1;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [3:0] idx, output logic [31:0] d);
        tick();
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0;
        PADDR = {26'd0, idx, 2'b00};
        tick();
        PENABLE = 1'b1;
        d = PRDATA;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    function automatic logic [191:0] q_vec(input int base);
        logic [191:0] v;
        v = '0;
        for (int i = 0; i < 192 && (base + i) < q.size(); i++) v[191 - i] = q[base + i];
        return v;
    endfunction

    // Runs until the latch gap of the current frame has ended; hi = latch-high cycles
    task automatic wait_frame(input bit rnd, output int hi);
        int n;
        n  = 0;
        hi = 0;
        while (strip_latch !== 1'b1 && n < 20000) begin
            if (rnd) bit_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        bit_ready = 1'b1;
        checks++;
        if (strip_latch !== 1'b1) begin
            failures++;
            $display("FAIL frame_end_timeout strip_latch=%b required=1", strip_latch);
        end else begin
            while (strip_latch === 1'b1 && hi < c_LAT + 100) begin
                hi++;
                tick();
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        PRESERN = 1'b0;
        repeat (3) tick();
        checks++;
        if ({bit_valid, bit_data, strip_latch, irq, PREADY, PSLVERR} !== 6'b000010) begin
            failures++;
            $display("FAIL reset_outputs got=%b required=000010",
                     {bit_valid, bit_data, strip_latch, irq, PREADY, PSLVERR});
        end
        checks++;
        if (PRDATA !== 32'h0) begin
            failures++;
            $display("FAIL reset_prdata got=%h required=0", PRDATA);
        end
        PRESERN = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            apb_read(4'(i), rd);
            checks++;
            if (rd !== 32'h0) begin
                failures++;
                $display("FAIL reset_reg%0d got=%h required=0", i, rd);
            end
        end
    endtask

    task automatic test_registers();
        logic [31:0] rd;
        apb_write(4'd3, 32'hFFABCDEF);
        apb_read(4'd3, rd);
        checks++;
        if (rd !== 32'h00ABCDEF) begin
            failures++;
            $display("FAIL color3_rw got=%h required=00abcdef", rd);
        end
        apb_write(4'd15, 32'hFFFFFFFF);
        apb_read(4'd15, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL unmapped_read got=%h required=0", rd);
        end
        apb_write(4'd10, 32'h00000123);
        apb_read(4'd10, rd);
        checks++;
        if (rd !== 32'h00000123) begin
            failures++;
            $display("FAIL refresh_rw got=%h required=00000123", rd);
        end
        apb_write(4'd10, 32'h0);
        apb_write(4'd3, 32'h0);
    endtask

    task automatic test_single_frame();
        logic [31:0] rd;
        int base, hi;
        apb_write(4'd0, 32'h00FF0000);
        base = q.size();
        apb_write(4'd8, 32'h5);
        tick();
        checks++;
        if (bit_valid !== 1'b0) begin
            failures++;
            $display("FAIL latency_load bit_valid=%b required=0", bit_valid);
        end
        tick();
        checks++;
        if (bit_valid !== 1'b1 || bit_data !== 1'b1) begin
            failures++;
            $display("FAIL latency_first_bit valid/data=%b%b required=11", bit_valid, bit_data);
        end
        wait_frame(1'b0, hi);
        checks++;
        if (q.size() - base != 192) begin
            failures++;
            $display("FAIL frame1_len got=%0d required=192", q.size() - base);
        end
        checks++;
        if (q_vec(base) !== c_FRAME_RED) begin
            failures++;
            $display("FAIL frame1_bits got=%h required=%h", q_vec(base), c_FRAME_RED);
        end
        checks++;
        if (hi != c_LAT) begin
            failures++;
            $display("FAIL latch_len got=%0d required=%0d", hi, c_LAT);
        end
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_after_frame got=%b required=1", irq);
        end
        apb_read(4'd9, rd);
        checks++;
        if (rd !== 32'h2) begin
            failures++;
            $display("FAIL status_done got=%h required=2", rd);
        end
        apb_read(4'd8, rd);
        checks++;
        if (rd !== 32'h4) begin
            failures++;
            $display("FAIL ctrl_read got=%h required=4", rd);
        end
    endtask

    task automatic test_backpressure();
        int base, hi, hv0;
        apb_write(4'd9, 32'h2);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_w1c got=%b required=0", irq);
        end
        hv0  = hold_viol;
        base = q.size();
        apb_write(4'd8, 32'h5);
        wait_frame(1'b1, hi);
        checks++;
        if (q_vec(base) !== c_FRAME_RED || q.size() - base != 192) begin
            failures++;
            $display("FAIL bp_bits len=%0d got=%h required=%h", q.size() - base, q_vec(base), c_FRAME_RED);
        end
        checks++;
        if (hold_viol != hv0) begin
            failures++;
            $display("FAIL bp_hold got=%0d required=0", hold_viol - hv0);
        end
        checks++;
        if (hi != c_LAT) begin
            failures++;
            $display("FAIL bp_latch_len got=%0d required=%0d", hi, c_LAT);
        end
    endtask

    task automatic test_shadow();
        logic [31:0] rd;
        int base1, base2, hi, n;
        apb_write(4'd9, 32'h2);
        base1 = q.size();
        apb_write(4'd8, 32'h1);
        n = 0;
        while (q.size() - base1 < 40 && n < 500) begin tick(); n++; end
        apb_write(4'd0, 32'h0000FF00);
        apb_write(4'd8, 32'h1);
        apb_write(4'd8, 32'h1);
        apb_read(4'd9, rd);
        checks++;
        if (rd !== 32'h5) begin
            failures++;
            $display("FAIL busy_pending got=%h required=5", rd);
        end
        wait_frame(1'b0, hi);
        checks++;
        if (q_vec(base1) !== c_FRAME_RED) begin
            failures++;
            $display("FAIL shadow_isolation got=%h required=%h", q_vec(base1), c_FRAME_RED);
        end
        base2 = q.size();
        wait_frame(1'b0, hi);
        repeat (30) tick();
        checks++;
        if (q_vec(base2) !== c_FRAME_GREEN || q.size() - base2 != 192) begin
            failures++;
            $display("FAIL pending_frame len=%0d got=%h required=%h", q.size() - base2, q_vec(base2), c_FRAME_GREEN);
        end
        apb_read(4'd9, rd);
        checks++;
        if (rd !== 32'h2) begin
            failures++;
            $display("FAIL single_pending got=%h required=2", rd);
        end
    endtask

    task automatic test_auto();
        logic [31:0] rd;
        int n, hi, t_c, t_d;
        apb_write(4'd9, 32'h2);
        apb_write(4'd10, 32'h0);
        apb_write(4'd8, 32'h2);
        n = 0;
        while (strip_latch !== 1'b1 && n < 2000) begin tick(); n++; end
        checks++;
        if (strip_latch !== 1'b1) begin
            failures++;
            $display("FAIL auto_first_frame strip_latch=%b required=1", strip_latch);
        end
        // W1C access edge lands on the edge that sets DONE
        repeat (c_LAT - 3) tick();
        apb_write(4'd9, 32'h2);
        checks++;
        if (strip_latch !== 1'b0) begin
            failures++;
            $display("FAIL auto_latch_end strip_latch=%b required=0", strip_latch);
        end
        tick();
        tick();
        checks++;
        if (bit_valid !== 1'b1) begin
            failures++;
            $display("FAIL refresh0_b2b bit_valid=%b required=1", bit_valid);
        end
        apb_read(4'd9, rd);
        checks++;
        if (rd !== 32'h3) begin
            failures++;
            $display("FAIL done_w1c_collision got=%h required=3", rd);
        end
        apb_write(4'd10, 32'd20000);
        wait_frame(1'b0, hi);
        n = 0;
        while (bit_valid !== 1'b1 && n < 100) begin tick(); n++; end
        t_c = cyc;
        wait_frame(1'b0, hi);
        n = 0;
        while (bit_valid !== 1'b1 && n < 25000) begin tick(); n++; end
        t_d = cyc;
        checks++;
        if (t_d - t_c != 20000) begin
            failures++;
            $display("FAIL refresh_period got=%0d required=20000", t_d - t_c);
        end
        apb_write(4'd8, 32'h0);
        wait_frame(1'b0, hi);
        checks++;
        if (hi != c_LAT) begin
            failures++;
            $display("FAIL auto_off_latch got=%0d required=%0d", hi, c_LAT);
        end
        repeat (50) tick();
        apb_read(4'd9, rd);
        checks++;
        if (rd !== 32'h2) begin
            failures++;
            $display("FAIL auto_off_idle got=%h required=2", rd);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] rd;
        int base, n, seen;
        apb_write(4'd9, 32'h2);
        base = q.size();
        apb_write(4'd8, 32'h5);
        n = 0;
        while (q.size() - base < 50 && n < 500) begin tick(); n++; end
        PRESERN = 1'b0;
        tick();
        checks++;
        if ({bit_valid, strip_latch, irq} !== 3'b000) begin
            failures++;
            $display("FAIL midframe_reset got=%b required=000", {bit_valid, strip_latch, irq});
        end
        PRESERN = 1'b1;
        seen = 0;
        repeat (40) begin
            tick();
            if (bit_valid === 1'b1 || strip_latch === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL midframe_no_resume got=%0d required=0", seen);
        end
        apb_read(4'd9, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL midframe_status got=%h required=0", rd);
        end
        apb_read(4'd0, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL midframe_color0 got=%h required=0", rd);
        end
        apb_read(4'd8, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL midframe_ctrl got=%h required=0", rd);
        end
    endtask

    initial begin
        test_reset();
        test_registers();
        test_single_frame();
        test_backpressure();
        test_shadow();
        test_auto();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
